// File: rtl/logic_op_sequencer_if.sv
// Board I/O bundle for logic_op_sequencer: raw slide switches and centre button in, LEDs out.
interface logic_op_sequencer_if;
    logic [1:0] SW;
    logic       BTNC;
    logic [3:0] LED;

    modport slave  (input SW, input BTNC, output LED);
    modport master (output SW, output BTNC, input LED);
endinterface

// File: rtl/logic_op_sequencer.sv
// Synchronises and debounces BTNC, steps the NOT/AND/OR/XOR mode on each press and shows the result on LED.
// Optional macro AUTO_STEP_EN adds a free-running auto-step timer of STEP_CYCLES cycles.
module logic_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 100_000_000
) (
    input  logic                clk,
    input  logic                reset,
    logic_op_sequencer_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || STEP_CYCLES < 2) begin : g_param_check
        $error("logic_op_sequencer: DEBOUNCE_CYCLES and STEP_CYCLES must be >= 2");
    end

    // state | meaning: MODE_NOT | ~SW[0], MODE_AND | SW[1]&SW[0], MODE_OR | SW[1]|SW[0], MODE_XOR | SW[1]^SW[0]
    typedef enum logic [1:0] {
        MODE_NOT = 2'd0,
        MODE_AND = 2'd1,
        MODE_OR  = 2'd2,
        MODE_XOR = 2'd3
    } mode_t;

    logic [1:0]      r_sw_m;
    logic [1:0]      r_sw_s;
    logic            r_btn_m;
    logic            r_btn_s;
    logic            r_btn_db;
    logic            r_btn_db_q;
    logic [DB_W-1:0] r_db_cnt;
    mode_t           r_mode;
    logic [3:0]      r_led;
    logic            w_press;
    logic            w_step;
    logic            w_result;

    assign w_press = r_btn_db & ~r_btn_db_q;

`ifdef AUTO_STEP_EN
    localparam int STEP_W = $clog2(STEP_CYCLES);

    logic [STEP_W-1:0] r_step_cnt;
    logic              w_auto;

    // A press and an auto tick landing together collapse into one step and one reload.
    assign w_auto = (r_step_cnt == STEP_W'(STEP_CYCLES - 1));
    assign w_step = w_press | w_auto;

    always_ff @(posedge clk) begin
        if (reset || w_step) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + STEP_W'(1);
        end
    end
`else
    assign w_step = w_press;
`endif

    always_comb begin
        w_result = 1'b0;
        case (r_mode)
            MODE_NOT: w_result = ~r_sw_s[0];
            MODE_AND: w_result = r_sw_s[1] & r_sw_s[0];
            MODE_OR:  w_result = r_sw_s[1] | r_sw_s[0];
            MODE_XOR: w_result = r_sw_s[1] ^ r_sw_s[0];
            default:  w_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_m     <= '0;
            r_sw_s     <= '0;
            r_btn_m    <= 1'b0;
            r_btn_s    <= 1'b0;
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
            r_db_cnt   <= '0;
            r_mode     <= MODE_NOT;
            r_led      <= '0;
        end else begin
            r_sw_m  <= bus.SW;
            r_sw_s  <= r_sw_m;
            r_btn_m <= bus.BTNC;
            r_btn_s <= r_btn_m;

            // Any cycle where the synced level agrees with the accepted level restarts the count.
            if (r_btn_s == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_btn_db <= r_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
            r_btn_db_q <= r_btn_db;

            if (w_step) begin
                case (r_mode)
                    MODE_NOT: r_mode <= MODE_AND;
                    MODE_AND: r_mode <= MODE_OR;
                    MODE_OR:  r_mode <= MODE_XOR;
                    MODE_XOR: r_mode <= MODE_NOT;
                    default:  r_mode <= MODE_NOT;
                endcase
            end

            r_led <= {r_mode, r_btn_db, w_result};
        end
    end

    assign bus.LED = r_led;
endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer: expected LED words are queued with a due cycle and checked at negedge.
module tb_logic_op_sequencer;
    typedef struct {
        string      tag;
        int         due;
        logic [3:0] exp;
    } exp_t;

`ifdef AUTO_STEP_EN
    localparam int A = 1;
`else
    localparam int A = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   mode   = 0;
    exp_t sb[$];

    logic_op_sequencer_if bus();

    logic_op_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checks++;
                assert (bus.LED === sb[i].exp) else begin
                    errors++;
                    $error("FAIL %s: LED=%b expected %b at cycle %0d", sb[i].tag, bus.LED, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    function automatic logic fres(int m, logic [1:0] sw);
        case (m % 4)
            0:       return ~sw[0];
            1:       return sw[1] & sw[0];
            2:       return sw[1] | sw[0];
            default: return sw[1] ^ sw[0];
        endcase
    endfunction

    function automatic logic [3:0] led_of(int m, logic [1:0] sw, logic db);
        logic [1:0] mm;
        mm = 2'(m % 4);
        return {mm, db, fres(m, sw)};
    endfunction

    task automatic expect_at(string tag, int due, logic [3:0] exp);
        sb.push_back('{tag, due, exp});
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press held 12 cycles then released; release must never step.
    task automatic press_step(string tag);
        logic [1:0] sw;
        int         c;
        sw = bus.SW;
        c  = cyc;
        bus.BTNC = 1'b1;
        expect_at({tag, "_pre"}, c + 7, led_of(mode, sw, 1'b1));
        mode = (mode + 1) % 4;
        expect_at({tag, "_post"}, c + 8, led_of(mode, sw, 1'b1));
        tick(12);
        bus.BTNC = 1'b0;
        expect_at({tag, "_hold"}, c + 18, led_of(mode, sw, 1'b1));
        expect_at({tag, "_rel"}, c + 19, led_of(mode, sw, 1'b0));
        expect_at({tag, "_stay"}, c + 24, led_of(mode, sw, 1'b0));
        tick(14);
    endtask

    initial begin
        logic [1:0] sw;
        logic [1:0] prev;
        int         c;
        int         r;

        bus.SW   = 2'b00;
        bus.BTNC = 1'b0;
        reset    = 1'b1;

        // reset: LED cleared while held, NOT of 0 after release
        tick(1);
        expect_at("rst_hold1", cyc + 1, 4'b0000);
        expect_at("rst_hold2", cyc + 2, 4'b0000);
        tick(2);
        reset = 1'b0;
        expect_at("rst_rel", cyc + 3, led_of(0, 2'b00, 1'b0));
        tick(3);

`ifndef AUTO_STEP_EN
        // NOT sweep, 3-cycle SW latency
        prev = 2'b00;
        for (int v = 0; v < 4; v++) begin
            bus.SW = 2'(v);
            expect_at("sw_early", cyc + 2, led_of(0, prev, 1'b0));
            expect_at("sw_lat3", cyc + 3, led_of(0, 2'(v), 1'b0));
            prev = 2'(v);
            tick(8);
        end

        // four clean presses wrap the mode back to NOT
        bus.SW = 2'b10;
        tick(4);
        press_step("p1");
        press_step("p2");
        press_step("p3");
        press_step("p4");

        // bouncy press gives exactly one step
        sw = bus.SW;
        bus.BTNC = 1'b1;
        tick(2);
        bus.BTNC = 1'b0;
        tick(1);
        bus.BTNC = 1'b1;
        c = cyc;
        expect_at("bnc_early", c + 6, led_of(mode, sw, 1'b0));
        expect_at("bnc_pre", c + 7, led_of(mode, sw, 1'b1));
        mode = (mode + 1) % 4;
        expect_at("bnc_step", c + 8, led_of(mode, sw, 1'b1));
        tick(10);
        bus.BTNC = 1'b0;
        expect_at("bnc_once", cyc + 12, led_of(mode, sw, 1'b0));
        tick(14);

        // 3-cycle pulse is shorter than the debounce window
        bus.BTNC = 1'b1;
        c = cyc;
        tick(3);
        bus.BTNC = 1'b0;
        expect_at("short_db", c + 7, led_of(mode, sw, 1'b0));
        expect_at("short_nostep", c + 15, led_of(mode, sw, 1'b0));
        tick(14);

        // reset mid-debounce from XOR aborts the pending press
        press_step("x1");
        press_step("x2");
        sw = bus.SW;
        bus.BTNC = 1'b1;
        tick(4);
        reset    = 1'b1;
        bus.BTNC = 1'b0;
        expect_at("rstdb_hold1", cyc + 1, 4'b0000);
        expect_at("rstdb_hold2", cyc + 2, 4'b0000);
        tick(2);
        reset = 1'b0;
        mode  = 0;
        expect_at("rstdb_rel", cyc + 1, led_of(0, sw, 1'b0));
        expect_at("rstdb_nostep", cyc + 15, led_of(0, sw, 1'b0));
        tick(16);
`endif

        // auto-step timing, press coinciding with a tick, press reloading the timer
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        r     = cyc;
        mode  = 0;
        sw    = bus.SW;
        expect_at("auto_pre", r + 16, led_of(0, sw, 1'b0));
        expect_at("auto_1", r + 17, led_of(A, sw, 1'b0));
        expect_at("auto_2", r + 33, led_of(2 * A, sw, 1'b0));
        tick(41);
        bus.BTNC = 1'b1;
        expect_at("coin_pre", r + 48, led_of(2 * A, sw, 1'b1));
        expect_at("coin_once", r + 49, led_of(2 * A + 1, sw, 1'b1));
        tick(12);
        bus.BTNC = 1'b0;
        expect_at("coin_next_pre", r + 64, led_of(2 * A + 1, sw, 1'b0));
        expect_at("coin_next", r + 65, led_of(3 * A + 1, sw, 1'b0));
        tick(17);
        bus.BTNC = 1'b1;
        expect_at("rld_pre", r + 77, led_of(3 * A + 1, sw, 1'b1));
        expect_at("rld_step", r + 78, led_of(3 * A + 2, sw, 1'b1));
        expect_at("rld_noold", r + 81, led_of(3 * A + 2, sw, 1'b1));
        tick(12);
        bus.BTNC = 1'b0;
        expect_at("rld_pre2", r + 93, led_of(3 * A + 2, sw, 1'b0));
        expect_at("rld_auto", r + 94, led_of(4 * A + 2, sw, 1'b0));
        tick(16);

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
            checks += sb.size();
            errors += sb.size();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
